// File: rtl/vga_sync.sv
// Raster timing generator: walks column/row over the full frame including
// blanking and registers sync, visible and start strobes for the same pixel.
module vga_sync #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int COORD_BITS = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic [COORD_BITS-1:0] column_o,
    output logic [COORD_BITS-1:0] row_o,
    output logic                  visible_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  line_start_o,
    output logic                  frame_start_o
);
    localparam int CB      = COORD_BITS;
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CB-1:0] H_LAST = CB'(H_TOTAL - 1);
    localparam logic [CB-1:0] V_LAST = CB'(V_TOTAL - 1);

    // One extra bit so a sync end equal to 2**CB still compares correctly.
    localparam logic [CB:0] H_VIS  = (CB+1)'(H_VISIBLE);
    localparam logic [CB:0] V_VIS  = (CB+1)'(V_VISIBLE);
    localparam logic [CB:0] HS_BEG = (CB+1)'(H_VISIBLE + H_FRONT);
    localparam logic [CB:0] HS_END = (CB+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CB:0] VS_BEG = (CB+1)'(V_VISIBLE + V_FRONT);
    localparam logic [CB:0] VS_END = (CB+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    // Low until the first edge after reset, so that edge presents pixel (0,0).
    logic          running;
    logic [CB-1:0] col_n;
    logic [CB-1:0] row_n;
    logic [CB:0]   col_x;
    logic [CB:0]   row_x;

    always_comb begin
        col_n = '0;
        row_n = '0;
        if (running) begin
            if (column_o == H_LAST) begin
                col_n = '0;
                row_n = (row_o == V_LAST) ? '0 : row_o + 1'b1;
            end else begin
                col_n = column_o + 1'b1;
                row_n = row_o;
            end
        end
    end

    assign col_x = {1'b0, col_n};
    assign row_x = {1'b0, row_n};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            running       <= 1'b0;
            column_o      <= '0;
            row_o         <= '0;
            visible_o     <= 1'b0;
            hsync_o       <= ~H_SYNC_POL;
            vsync_o       <= ~V_SYNC_POL;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            running       <= 1'b1;
            column_o      <= col_n;
            row_o         <= row_n;
            visible_o     <= (col_x < H_VIS) && (row_x < V_VIS);
            hsync_o       <= ((col_x >= HS_BEG) && (col_x < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_o       <= ((row_x >= VS_BEG) && (row_x < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
            line_start_o  <= (col_n == '0);
            frame_start_o <= (col_n == '0) && (row_n == '0);
        end
    end
endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench for vga_sync: three configurations share clock and reset,
// a linear-pixel-index reference model predicts every output each cycle.
module tb_vga_sync;
    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       vis;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } pix_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] c0, r0, c1, r1, c2, r2;
    logic v0, h0, s0, l0, f0, v1, h1, s1, l1, f1, v2, h2, s2, l2, f2;
    pix_t got0, got1, got2;
    assign got0 = {c0, r0, v0, h0, s0, l0, f0};
    assign got1 = {c1, r1, v1, h1, s1, l1, f1};
    assign got2 = {c2, r2, v2, h2, s2, l2, f2};

    // default 640x480
    vga_sync dut0 (.clk_i(clk), .rst_ni(rst_n), .column_o(c0), .row_o(r0),
        .visible_o(v0), .hsync_o(h0), .vsync_o(s0), .line_start_o(l0), .frame_start_o(f0));

    // tiny 8x6 frame, active-high syncs
    vga_sync #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
               .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
               .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .column_o(c1), .row_o(r1),
        .visible_o(v1), .hsync_o(h1), .vsync_o(s1), .line_start_o(l1), .frame_start_o(f1));

    // default line, 10-line frame so whole frames fit in the run
    vga_sync #(.V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .column_o(c2), .row_o(r2),
        .visible_o(v2), .hsync_o(h2), .vsync_o(s2), .line_start_o(l2), .frame_start_o(f2));

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int pa = -1, pb = -1, pc = -1;
    int last_ls0 = -1, last_fs1 = -1, last_fs2 = -1;
    pix_t q0[$], q1[$], q2[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // p < 0 means held in reset; otherwise p is the linear pixel index in the frame
    function automatic pix_t ref_pix(int hv, int hf, int hsw, int hb, int vv, int vf, int vsw,
                                     bit hp, bit vp, int p);
        int   ht = hv + hf + hsw + hb;
        int   c, r;
        pix_t x;
        x = '0;
        if (p < 0) begin
            x.hs = ~hp;
            x.vs = ~vp;
            return x;
        end
        c = p % ht;
        r = p / ht;
        x.col = 10'(c);
        x.row = 10'(r);
        x.vis = (c < hv) && (r < vv);
        x.hs  = (c >= hv + hf && c < hv + hf + hsw) ? hp : ~hp;
        x.vs  = (r >= vv + vf && r < vv + vf + vsw) ? vp : ~vp;
        x.ls  = (c == 0);
        x.fs  = (p == 0);
        return x;
    endfunction

    function automatic int adv(int p, bit r, int total);
        if (!r) return -1;
        return (p < 0) ? 0 : (p + 1) % total;
    endfunction

    task automatic tick(input bit r);
        pix_t e0, e1, e2;
        @(negedge clk);
        if (!r && rst_n) begin
            rst_n = 1'b0;
            #1;
            chk("async_rst", 64'(got0), 64'(ref_pix(640, 16, 96, 48, 480, 10, 2, 0, 0, -1)));
        end
        rst_n = r;
        pa = adv(pa, r, 800 * 525);
        pb = adv(pb, r, 8 * 6);
        pc = adv(pc, r, 800 * 10);
        q0.push_back(ref_pix(640, 16, 96, 48, 480, 10, 2, 0, 0, pa));
        q1.push_back(ref_pix(4, 1, 2, 1, 3, 1, 1, 1, 1, pb));
        q2.push_back(ref_pix(640, 16, 96, 48, 4, 2, 2, 0, 0, pc));
        if (!r) begin
            last_ls0 = -1;
            last_fs1 = -1;
            last_fs2 = -1;
        end
        @(posedge clk);
        #1;
        cyc++;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        chk("dflt", 64'(got0), 64'(e0));
        chk("small", 64'(got1), 64'(e1));
        chk("tall", 64'(got2), 64'(e2));
        chk("bound_small", 64'((c1 < 10'd8) && (r1 < 10'd6)), 64'd1);
        chk("bound_tall", 64'((c2 < 10'd800) && (r2 < 10'd10)), 64'd1);
        if (pa == 800) chk("wrap_row1", 64'({c0, r0, l0}), 64'({10'd0, 10'd1, 1'b1}));
        if (l0 === 1'b1) begin
            if (last_ls0 >= 0) chk("line_period", 64'(cyc - last_ls0), 64'd800);
            last_ls0 = cyc;
        end
        if (f1 === 1'b1) begin
            if (last_fs1 >= 0) chk("frame_period_small", 64'(cyc - last_fs1), 64'd48);
            last_fs1 = cyc;
        end
        if (f2 === 1'b1) begin
            if (last_fs2 >= 0) chk("frame_period_tall", 64'(cyc - last_fs2), 64'd8000);
            last_fs2 = cyc;
        end
    endtask

    initial begin
        int guard;
        repeat (5) tick(1'b0);
        tick(1'b1);
        chk("first_pix", 64'(got0), 64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}));

        // run to row 2, col 123 of the default frame, then pulse reset
        guard = 0;
        while (pa != 2 * 800 + 123 && guard < 5000) begin
            tick(1'b1);
            guard++;
        end
        chk("reach_row2_col123", 64'(pa), 64'(2 * 800 + 123));
        tick(1'b0);
        tick(1'b1);
        chk("restart_pix", 64'({c0, r0, v0, l0, f0}), 64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1}));

        repeat (17000) tick(1'b1);
        repeat (15000) tick($urandom_range(0, 1999) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
